// File: rtl/cpu_control_fsm.sv
// Control sequencer for a small accumulator CPU. It walks fetch, decode,
// execute and write-back phases, issues the datapath strobes for each phase,
// and guards every memory access with a wait-cycle timeout that lands in ERROR.
module cpu_control_fsm #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] instr,
    input  logic       zero_flag,
    input  logic       mem_ready,
    output logic       mar_sel,
    output logic       mar_load,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       acc_load,
    output logic       out_load,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic       bus_error,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        FETCH_A = 3'd0,
        FETCH_M = 3'd1,
        DECODE  = 3'd2,
        EXEC_A  = 3'd3,
        EXEC_M  = 3'd4,
        WB      = 3'd5,
        HALT    = 3'd6,
        ERROR   = 3'd7
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'h8;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] ALU_MEM = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_IMM = 2'b11;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     cur_state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;
    logic [3:0] opcode;
    logic       wait_timeout;
    logic       unused_operand_bits;

    // The operand nibble feeds the datapath directly; only the opcode steers control.
    assign opcode              = instr[7:4];
    assign unused_operand_bits = ^instr[3:0];
    assign wait_timeout        = (wait_cnt == WAIT_LAST) && !mem_ready;

    assign state     = cur_state;
    assign halted    = (cur_state == HALT);
    assign bus_error = (cur_state == ERROR);

    // State register and wait counter, both cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state <= FETCH_A;
            wait_cnt  <= 8'd0;
        end else begin
            cur_state <= next_state;
            wait_cnt  <= wait_cnt_next;
        end
    end

    // Next-state, wait-counter and strobe decode; reset overrides every strobe.
    always_comb begin
        next_state    = cur_state;
        wait_cnt_next = wait_cnt;
        mar_sel       = 1'b0;
        mar_load      = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        ir_load       = 1'b0;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
        acc_load      = 1'b0;
        out_load      = 1'b0;
        alu_op        = ALU_MEM;

        case (cur_state)
            FETCH_A: begin
                mar_load      = 1'b1;
                wait_cnt_next = 8'd0;
                next_state    = FETCH_M;
            end
            FETCH_M: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_load    = 1'b1;
                    pc_inc     = 1'b1;
                    next_state = DECODE;
                end else if (wait_timeout) begin
                    next_state = ERROR;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            DECODE: begin
                next_state = FETCH_A;
                case (opcode)
                    OP_LDI: begin
                        acc_load = 1'b1;
                        alu_op   = ALU_IMM;
                    end
                    OP_JMP:  pc_load  = 1'b1;
                    OP_JZ:   pc_load  = zero_flag;
                    OP_OUT:  out_load = 1'b1;
                    OP_HLT:  next_state = HALT;
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: next_state = EXEC_A;
                    default: next_state = FETCH_A;
                endcase
            end
            EXEC_A: begin
                mar_sel       = 1'b1;
                mar_load      = 1'b1;
                wait_cnt_next = 8'd0;
                next_state    = EXEC_M;
            end
            EXEC_M: begin
                if (opcode == OP_STA) begin
                    mem_wr = 1'b1;
                end else begin
                    mem_rd = 1'b1;
                end
                if (mem_ready) begin
                    next_state = (opcode == OP_STA) ? FETCH_A : WB;
                end else if (wait_timeout) begin
                    next_state = ERROR;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            WB: begin
                acc_load   = 1'b1;
                next_state = FETCH_A;
                case (opcode)
                    OP_ADD:  alu_op = ALU_ADD;
                    OP_SUB:  alu_op = ALU_SUB;
                    default: alu_op = ALU_MEM;
                endcase
            end
            HALT:    next_state = HALT;
            ERROR:   next_state = ERROR;
            default: next_state = ERROR;
        endcase

        if (!reset) begin
            mar_sel  = 1'b0;
            mar_load = 1'b0;
            mem_rd   = 1'b0;
            mem_wr   = 1'b0;
            ir_load  = 1'b0;
            pc_inc   = 1'b0;
            pc_load  = 1'b0;
            acc_load = 1'b0;
            out_load = 1'b0;
            alu_op   = ALU_MEM;
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm. Instructions are expanded, from
// the phase rules of the instruction set, into a queue of expected
// per-cycle records (inputs to drive, state and strobes to expect), which
// are then replayed against the DUT.
module tb_cpu_control_fsm;

    localparam int WAIT_MAX = 15;

    // Strobe vector layout:
    // {mar_sel, mar_load, mem_rd, mem_wr, ir_load, pc_inc, pc_load,
    //  acc_load, out_load, alu_op[1:0], halted, bus_error}
    localparam logic [12:0] B_NONE     = 13'h0000;
    localparam logic [12:0] B_MAR_SEL  = 13'h1000;
    localparam logic [12:0] B_MAR_LOAD = 13'h0800;
    localparam logic [12:0] B_MEM_RD   = 13'h0400;
    localparam logic [12:0] B_MEM_WR   = 13'h0200;
    localparam logic [12:0] B_IR_LOAD  = 13'h0100;
    localparam logic [12:0] B_PC_INC   = 13'h0080;
    localparam logic [12:0] B_PC_LOAD  = 13'h0040;
    localparam logic [12:0] B_ACC_LOAD = 13'h0020;
    localparam logic [12:0] B_OUT_LOAD = 13'h0010;
    localparam logic [12:0] ALU_ADD    = 13'h0004;
    localparam logic [12:0] ALU_SUB    = 13'h0008;
    localparam logic [12:0] ALU_IMM    = 13'h000C;
    localparam logic [12:0] B_HALTED   = 13'h0002;
    localparam logic [12:0] B_BUS_ERR  = 13'h0001;

    typedef struct {
        logic       rst;
        logic       mr;
        logic       zf;
        logic [7:0] ins;
        logic [2:0] st;
        logic [12:0] sb;
    } cycle_t;

    logic        clk;
    logic        reset;
    logic [7:0]  instr;
    logic        zero_flag;
    logic        mem_ready;
    logic        mar_sel, mar_load, mem_rd, mem_wr, ir_load, pc_inc;
    logic        pc_load, acc_load, out_load;
    logic [1:0]  alu_op;
    logic        halted, bus_error;
    logic [2:0]  state;
    logic [12:0] obs;

    cycle_t      exp_q[$];
    logic [2:0]  model_st;
    int          checks;
    int          errors;
    int          cycle_no;

    cpu_control_fsm #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .zero_flag (zero_flag),
        .mem_ready (mem_ready),
        .mar_sel   (mar_sel),
        .mar_load  (mar_load),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .acc_load  (acc_load),
        .out_load  (out_load),
        .alu_op    (alu_op),
        .halted    (halted),
        .bus_error (bus_error),
        .state     (state)
    );

    assign obs = {mar_sel, mar_load, mem_rd, mem_wr, ir_load, pc_inc, pc_load,
                  acc_load, out_load, alu_op, halted, bus_error};

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic rst, input logic mr, input logic zf,
                        input logic [7:0] ins, input logic [2:0] st,
                        input logic [12:0] sb);
        cycle_t c;
        c.rst = rst;
        c.mr  = mr;
        c.zf  = zf;
        c.ins = ins;
        c.st  = st;
        c.sb  = sb;
        exp_q.push_back(c);
    endtask

    // Terminal states only show their flag; everything else stays quiet.
    function automatic logic [12:0] idle_flags(input logic [2:0] st);
        if (st == 3'd6) return B_HALTED;
        if (st == 3'd7) return B_BUS_ERR;
        return B_NONE;
    endfunction

    // Hold reset low for n cycles: the first shows the pre-reset state with
    // strobes forced off, the rest sit in state 0.
    task automatic gen_reset(input int n);
        logic [2:0] st;
        for (int i = 0; i < n; i++) begin
            st = (i == 0) ? model_st : 3'd0;
            push(1'b0, rnd_bit(), rnd_bit(), 8'($urandom), st, idle_flags(st));
        end
        model_st = 3'd0;
    endtask

    // Cycles spent parked in HALT or ERROR with noisy inputs.
    task automatic gen_terminal(input int n);
        for (int i = 0; i < n; i++) begin
            push(1'b1, rnd_bit(), rnd_bit(), 8'($urandom), model_st, idle_flags(model_st));
        end
    endtask

    // Expand one instruction into its expected cycles. fwait/ewait are the
    // number of not-ready cycles in the fetch and execute accesses; a wait of
    // WAIT_MAX or more times out into ERROR. abort_exec stops the expansion
    // mid-wait in the execute access so a reset can be injected there.
    task automatic gen_instr(input logic [7:0] ins, input int fwait, input int ewait,
                             input logic zf_dec, input bit abort_exec);
        logic [3:0]  op;
        logic [12:0] acc_strobe;
        logic [12:0] wb_alu;
        op = ins[7:4];
        push(1'b1, rnd_bit(), rnd_bit(), ins, 3'd0, B_MAR_LOAD);
        for (int i = 0; i < fwait && i < WAIT_MAX; i++)
            push(1'b1, 1'b0, rnd_bit(), ins, 3'd1, B_MEM_RD);
        if (fwait >= WAIT_MAX) begin
            model_st = 3'd7;
        end else begin
            push(1'b1, 1'b1, rnd_bit(), ins, 3'd1, B_MEM_RD | B_IR_LOAD | B_PC_INC);
            model_st = 3'd0;
            case (op)
                4'h5: push(1'b1, rnd_bit(), zf_dec, ins, 3'd2, B_ACC_LOAD | ALU_IMM);
                4'h6: push(1'b1, rnd_bit(), zf_dec, ins, 3'd2, B_PC_LOAD);
                4'h7: push(1'b1, rnd_bit(), zf_dec, ins, 3'd2, zf_dec ? B_PC_LOAD : B_NONE);
                4'h8: push(1'b1, rnd_bit(), zf_dec, ins, 3'd2, B_OUT_LOAD);
                4'hF: begin
                    push(1'b1, rnd_bit(), zf_dec, ins, 3'd2, B_NONE);
                    model_st = 3'd6;
                end
                4'h1, 4'h2, 4'h3, 4'h4: begin
                    push(1'b1, rnd_bit(), zf_dec, ins, 3'd2, B_NONE);
                    push(1'b1, rnd_bit(), rnd_bit(), ins, 3'd3, B_MAR_SEL | B_MAR_LOAD);
                    acc_strobe = (op == 4'h4) ? B_MEM_WR : B_MEM_RD;
                    for (int i = 0; i < ewait && i < WAIT_MAX; i++)
                        push(1'b1, 1'b0, rnd_bit(), ins, 3'd4, acc_strobe);
                    if (abort_exec) begin
                        model_st = 3'd4;
                    end else if (ewait >= WAIT_MAX) begin
                        model_st = 3'd7;
                    end else begin
                        push(1'b1, 1'b1, rnd_bit(), ins, 3'd4, acc_strobe);
                        if (op != 4'h4) begin
                            wb_alu = (op == 4'h2) ? ALU_ADD : (op == 4'h3) ? ALU_SUB : B_NONE;
                            push(1'b1, rnd_bit(), rnd_bit(), ins, 3'd5, B_ACC_LOAD | wb_alu);
                        end
                    end
                end
                default: push(1'b1, rnd_bit(), zf_dec, ins, 3'd2, B_NONE);
            endcase
        end
    endtask

    // Drive one cycle's inputs.
    task automatic applyStimulus(input cycle_t c);
        reset     = c.rst;
        mem_ready = c.mr;
        zero_flag = c.zf;
        instr     = c.ins;
    endtask

    // Compare state and strobe vector against the expected record.
    task automatic checkOutput(input cycle_t c);
        checks++;
        assert (state === c.st) else begin
            errors++;
            $error("[TB] FAIL state cycle %0d instr %h: got %0d expected %0d",
                   cycle_no, c.ins, state, c.st);
        end
        checks++;
        assert (obs === c.sb) else begin
            errors++;
            $error("[TB] FAIL strobes cycle %0d instr %h state %0d: got %b expected %b",
                   cycle_no, c.ins, c.st, obs, c.sb);
        end
    endtask

    // Directed scenarios followed by a random instruction stream, all replayed in order.
    initial begin
        cycle_t     c;
        logic [7:0] rins;
        int         fw;
        int         ew;

        checks    = 0;
        errors    = 0;
        cycle_no  = 0;
        model_st  = 3'd0;
        reset     = 1'b0;
        mem_ready = 1'b0;
        zero_flag = 1'b0;
        instr     = 8'h00;
        repeat (2) @(posedge clk);
        #1;

        gen_reset(2);
        gen_instr(8'h53, 0, 0, rnd_bit(), 1'b0);
        gen_instr(8'h27, 0, 0, rnd_bit(), 1'b0);
        gen_instr(8'h4A, 0, 3, rnd_bit(), 1'b0);
        gen_instr(8'h75, 0, 0, 1'b0, 1'b0);
        gen_instr(8'h75, 0, 0, 1'b1, 1'b0);
        gen_instr(8'h1C, WAIT_MAX - 1, 0, rnd_bit(), 1'b0);
        gen_instr(8'h3E, 0, WAIT_MAX - 1, rnd_bit(), 1'b0);

        for (int n = 0; n < 40; n++) begin
            rins = {4'($urandom_range(0, 14)), 4'($urandom)};
            fw   = ($urandom_range(0, 7) == 0) ? WAIT_MAX - 1 : int'($urandom_range(0, 2));
            ew   = ($urandom_range(0, 7) == 0) ? WAIT_MAX - 1 : int'($urandom_range(0, 2));
            gen_instr(rins, fw, ew, rnd_bit(), 1'b0);
        end

        gen_instr(8'h25, 0, WAIT_MAX, rnd_bit(), 1'b0);
        gen_terminal(5);
        gen_reset(2);
        gen_instr(8'h00, WAIT_MAX, 0, rnd_bit(), 1'b0);
        gen_terminal(10);
        gen_reset(2);
        gen_instr(8'hF0, 0, 0, rnd_bit(), 1'b0);
        gen_terminal(20);
        gen_reset(2);
        gen_instr(8'h1C, 0, 3, rnd_bit(), 1'b1);
        gen_reset(2);
        gen_instr(8'h53, 0, 0, rnd_bit(), 1'b0);
        gen_instr(8'h86, 1, 0, rnd_bit(), 1'b0);

        $display("[TB] replaying %0d expected cycles", exp_q.size());
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            applyStimulus(c);
            #1;
            checkOutput(c);
            @(posedge clk);
            #1;
            cycle_no++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 Parameter: WAIT_MAX, 15, maximum cycles a memory access may wait for mem_ready (range 1-255).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk; reset==0 resets the block.
REQ-004 instr  input  8  instruction register contents; [7:4] opcode, [3:0] operand/address.
REQ-005 zero_flag  input  1  accumulator-zero flag from the datapath.
REQ-006 mem_ready  input  1  memory handshake; completes the pending access in the cycle it is high.
REQ-007 mar_sel  output  1  MAR source: 0 = PC, 1 = instr[3:0].
REQ-008 mar_load, mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load, out_load  output  1 each  datapath strobes.
REQ-009 alu_op  output  2  accumulator source: 00 = memory data, 01 = ACC+mem, 10 = ACC-mem, 11 = immediate instr[3:0], zero-extended.
REQ-010 halted  output  1  high in HALT.
REQ-011 bus_error  output  1  high in ERROR.
REQ-012 state  output  3  current state encoding for debug.

Function
REQ-013 States and encodings: FETCH_A=0, FETCH_M=1, DECODE=2, EXEC_A=3, EXEC_M=4, WB=5, HALT=6, ERROR=7; one state register.
REQ-014 Strobes are decoded from the current state, instr, zero_flag and mem_ready; unlisted strobes are 0.
REQ-015 FETCH_A: mar_sel=0, mar_load=1; next state FETCH_M.
REQ-016 FETCH_M: mem_rd=1 held every cycle. When mem_ready=1, ir_load=1 and pc_inc=1 in that cycle, and next state is DECODE. Otherwise the state holds.
REQ-017 DECODE by opcode:
- 0 NOP -> FETCH_A.
- 5 LDI: acc_load=1, alu_op=11 -> FETCH_A.
- 6 JMP: pc_load=1 -> FETCH_A.
- 7 JZ: pc_load=zero_flag -> FETCH_A.
- 8 OUT: out_load=1 -> FETCH_A.
- F HLT -> HALT.
- 1 LDA, 2 ADD, 3 SUB, 4 STA -> EXEC_A.
- Opcodes 9-E are treated as NOP.
REQ-018 EXEC_A: mar_sel=1, mar_load=1; next state EXEC_M.
REQ-019 EXEC_M: mem_wr=1 for STA, mem_rd=1 otherwise, held stable while waiting. On mem_ready=1, STA goes to FETCH_A and all others go to WB.
REQ-020 WB: acc_load=1; alu_op is 00 for LDA, 01 for ADD, 10 for SUB; next state FETCH_A.
REQ-021 With zero-wait memory (mem_ready held high), instruction latency in cycles:
- NOP, LDI, JMP, JZ, OUT: 3.
- STA: 5.
- LDA, ADD, SUB: 6.
REQ-022 An 8-bit wait counter clears on entry to FETCH_M or EXEC_M and increments each cycle mem_ready=0 in those states.
REQ-023 If the wait counter equals WAIT_MAX-1 and mem_ready=0, the next state is ERROR.
REQ-024 mem_ready is ignored outside FETCH_M and EXEC_M.
REQ-025 HALT and ERROR are terminal: all strobes are 0 and only reset exits them.
REQ-026 instr is stable from the cycle after ir_load until the next ir_load; the block does not latch it.

Reset
REQ-027 reset==0 at a clk edge sets state=FETCH_A, clears the wait counter, and drives halted=0, bus_error=0; this applies from any state, including mid-wait.
REQ-028 While reset==0, all strobes are forced to 0 and alu_op=00.
REQ-029 The first cycle after reset deasserts is FETCH_A, with mar_load=1.

Verification
REQ-030 Reset release, mem_ready tied 1, instr=0x53 (LDI 3): state sequence 0,1,2,0; acc_load=1 with alu_op=11 in cycle 3; pc_inc exactly once.
REQ-031 instr=0x27 (ADD 7), zero-wait: states 0,1,2,3,4,5; mar_sel=1 in state 3; mem_rd=1 in states 1 and 4; acc_load with alu_op=01 in state 5.
REQ-032 instr=0x4A (STA 10), mem_ready low for 3 cycles in EXEC_M: mem_wr held 4 cycles, then FETCH_A; no acc_load.
REQ-033 instr=0x7x with zero_flag=0, then zero_flag=1: pc_load=0, then pc_load=1 in DECODE.
REQ-034 WAIT_MAX=15, mem_ready stuck 0 in FETCH_M: ERROR entered after exactly 15 FETCH_M cycles; bus_error=1 and stays; reset==0 returns to state 0.
REQ-035 instr=0xF0: HALT reached; halted=1 and strobes stay 0 for 20 cycles; reset==0 asserted mid-wait in EXEC_M aborts to FETCH_A with mem_rd=0.
